// File: rtl/control_gw_packet_arbiter.sv
// Packet-level round-robin arbiter for the AXI-Stream path into the control gateway
// bridge. The owner holds the output until its tlast beat is accepted; output is registered.

module control_gw_packet_arbiter_lane (
  input  logic grant,
  input  logic busy,
  input  logic slot_free,
  input  logic valid,
  output logic ready,
  output logic accept
);
  assign ready  = busy & grant & slot_free;
  assign accept = ready & valid;
endmodule

module control_gw_packet_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = 8,
  parameter int IP_PORT_WIDTH    = 16,
  parameter int IP_ADDRESS_WIDTH = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_ap_rst,
  input  logic [NUM_REQ-1:0]                    req_tvalid,
  output logic [NUM_REQ-1:0]                    req_tready,
  input  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0]    req_tdata,
  input  logic [NUM_REQ*AXIS_KEEP_WIDTH-1:0]    req_tkeep,
  input  logic [NUM_REQ*IP_PORT_WIDTH-1:0]      req_tid,
  input  logic [NUM_REQ*IP_PORT_WIDTH-1:0]      req_tdest,
  input  logic [NUM_REQ*IP_ADDRESS_WIDTH-1:0]   req_tuser,
  input  logic [NUM_REQ-1:0]                    req_tlast,
  output logic                                  to_bridge_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]            to_bridge_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]            to_bridge_tkeep,
  output logic [IP_PORT_WIDTH-1:0]              to_bridge_tid,
  output logic [IP_PORT_WIDTH-1:0]              to_bridge_tdest,
  output logic [IP_ADDRESS_WIDTH-1:0]           to_bridge_tuser,
  output logic                                  to_bridge_tlast,
  input  logic                                  to_bridge_tready,
  output logic [NUM_REQ-1:0]                    o_grant,
  output logic                                  o_busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d, gidx_q, gidx_d, pick;
  logic [NUM_REQ-1:0] grant_d, lane_accept;
  logic               any_valid, slot_free, accept;

  function automatic logic [PTR_W-1:0] wrap_add(logic [PTR_W-1:0] a, int b);
    int s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // Walk the search order backwards so the highest-priority valid is written last.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_tvalid[wrap_add(ptr_q, i)]) begin
        pick      = wrap_add(ptr_q, i);
        any_valid = 1'b1;
      end
    end
  end

  assign slot_free = !to_bridge_tvalid || to_bridge_tready;
  assign o_busy    = (state_q == BUSY);

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_lane
      control_gw_packet_arbiter_lane u_lane (
        .grant     (o_grant[k]),
        .busy      (o_busy),
        .slot_free (slot_free),
        .valid     (req_tvalid[k]),
        .ready     (req_tready[k]),
        .accept    (lane_accept[k])
      );
    end
  endgenerate

  assign accept = |lane_accept;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = o_grant;
    case (state_q)
      IDLE: if (any_valid) begin
        gidx_d  = pick;
        grant_d = NUM_REQ'(1) << pick;
        state_d = BUSY;
      end
      BUSY: if (accept && req_tlast[gidx_q]) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = wrap_add(gidx_q, 1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      o_grant <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      o_grant <= grant_d;
    end
  end

  // Output register: loads on accept, holds under backpressure, empties when drained.
  always_ff @(posedge i_clk) begin
    if (i_ap_rst) begin
      to_bridge_tvalid <= 1'b0;
      to_bridge_tdata  <= '0;
      to_bridge_tkeep  <= '0;
      to_bridge_tid    <= '0;
      to_bridge_tdest  <= '0;
      to_bridge_tuser  <= '0;
      to_bridge_tlast  <= 1'b0;
    end else if (accept) begin
      to_bridge_tvalid <= 1'b1;
      to_bridge_tdata  <= req_tdata[gidx_q*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
      to_bridge_tkeep  <= req_tkeep[gidx_q*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
      to_bridge_tid    <= req_tid[gidx_q*IP_PORT_WIDTH +: IP_PORT_WIDTH];
      to_bridge_tdest  <= req_tdest[gidx_q*IP_PORT_WIDTH +: IP_PORT_WIDTH];
      to_bridge_tuser  <= req_tuser[gidx_q*IP_ADDRESS_WIDTH +: IP_ADDRESS_WIDTH];
      to_bridge_tlast  <= req_tlast[gidx_q];
    end else if (to_bridge_tready) begin
      to_bridge_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_control_gw_packet_arbiter.sv
// Bench for control_gw_packet_arbiter: directed scenarios plus a random phase,
// checked every cycle against a packet/queue-level reference model.
module tb_control_gw_packet_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [15:0] id;
    logic [15:0] dest;
    logic [31:0] user;
    logic        last;
  } beat_t;

  logic            clk, i_ap_rst;
  logic [N-1:0]    req_tvalid, req_tready, req_tlast, o_grant;
  logic [N*64-1:0] req_tdata;
  logic [N*8-1:0]  req_tkeep;
  logic [N*16-1:0] req_tid, req_tdest;
  logic [N*32-1:0] req_tuser;
  logic            to_bridge_tvalid, to_bridge_tlast, to_bridge_tready, o_busy;
  logic [63:0]     to_bridge_tdata;
  logic [7:0]      to_bridge_tkeep;
  logic [15:0]     to_bridge_tid, to_bridge_tdest;
  logic [31:0]     to_bridge_tuser;

  control_gw_packet_arbiter dut (
    .i_clk(clk), .i_ap_rst(i_ap_rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tid(req_tid), .req_tdest(req_tdest),
    .req_tuser(req_tuser), .req_tlast(req_tlast),
    .to_bridge_tvalid(to_bridge_tvalid), .to_bridge_tdata(to_bridge_tdata),
    .to_bridge_tkeep(to_bridge_tkeep), .to_bridge_tid(to_bridge_tid),
    .to_bridge_tdest(to_bridge_tdest), .to_bridge_tuser(to_bridge_tuser),
    .to_bridge_tlast(to_bridge_tlast), .to_bridge_tready(to_bridge_tready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Reference model state: sources, ownership, rr pointer, output slot.
  beat_t       srcq[N][$];
  bit          mbusy = 0, mov = 0;
  int          mown = 0, mptr = 0;
  beat_t       mob = '0;
  int          acc_cnt[N];
  int          owners[$];
  logic [63:0] got[$];
  logic [N-1:0] prev_grant = '0, en = '1;
  int          tr_mode = 0, pidx = 0, gen_cnt = 0;
  bit          rand_en = 0;
  logic        pat[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t rnd_beat(input bit last);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = 8'($urandom);
    b.id   = 16'($urandom);
    b.dest = 16'($urandom);
    b.user = $urandom;
    b.last = last;
    return b;
  endfunction

  task automatic enq(input int k, input int len);
    for (int j = 0; j < len; j++) srcq[k].push_back(rnd_beat(j == len - 1));
    gen_cnt += len;
  endtask

  task automatic step(input bit rst);
    logic [N-1:0] v, exp_rdy;
    logic         tr;
    bit           acc;
    beat_t        h;
    @(negedge clk);
    i_ap_rst = rst;
    case (tr_mode)
      0:       tr = 1'b1;
      1:       begin tr = pat[pidx % 4]; pidx++; end
      default: tr = ($urandom_range(0, 2) != 0);
    endcase
    to_bridge_tready = tr;
    for (int k = 0; k < N; k++) begin
      if (rand_en) en[k] = ($urandom_range(0, 4) != 0);
      v[k] = en[k] && (srcq[k].size() > 0);
      h = v[k] ? srcq[k][0] : '0;
      req_tvalid[k]          = v[k];
      req_tdata[k*64 +: 64]  = h.data;
      req_tkeep[k*8 +: 8]    = h.keep;
      req_tid[k*16 +: 16]    = h.id;
      req_tdest[k*16 +: 16]  = h.dest;
      req_tuser[k*32 +: 32]  = h.user;
      req_tlast[k]           = h.last;
    end
    #1;
    exp_rdy = (mbusy && (!mov || tr)) ? (N'(1) << mown) : '0;
    chk("busy",    64'(o_busy), 64'(mbusy));
    chk("grant",   64'(o_grant), mbusy ? 64'(N'(1) << mown) : 64'd0);
    chk("ready",   64'(req_tready), 64'(exp_rdy));
    chk("tvalid",  64'(to_bridge_tvalid), 64'(mov));
    chk("tdata",   to_bridge_tdata, mob.data);
    chk("tkeep",   64'(to_bridge_tkeep), 64'(mob.keep));
    chk("tid",     64'(to_bridge_tid), 64'(mob.id));
    chk("tdest",   64'(to_bridge_tdest), 64'(mob.dest));
    chk("tuser",   64'(to_bridge_tuser), 64'(mob.user));
    chk("tlast",   64'(to_bridge_tlast), 64'(mob.last));
    if (o_grant != 0 && prev_grant == 0)
      for (int k = 0; k < N; k++) if (o_grant[k]) owners.push_back(k);
    prev_grant = o_grant;
    if (to_bridge_tvalid && tr && !rst) got.push_back(to_bridge_tdata);
    // Advance the model across the coming clock edge.
    if (rst) begin
      mbusy = 0; mptr = 0; mov = 0; mob = '0;
    end else begin
      acc = 0;
      if (!mbusy) begin
        for (int i = 0; i < N; i++)
          if (v[(mptr + i) % N]) begin mown = (mptr + i) % N; mbusy = 1; break; end
      end else if (v[mown] && (!mov || tr)) begin
        acc = 1;
        mob = srcq[mown].pop_front();
        acc_cnt[mown]++;
        if (mob.last) begin mbusy = 0; mptr = (mown + 1) % N; end
      end
      if (acc) mov = 1; else if (tr) mov = 0;
    end
  endtask

  function automatic bit pending();
    bit p = mbusy || mov;
    for (int k = 0; k < N; k++) if (srcq[k].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while (pending() && n < max) begin step(0); n++; end
    chk("drain_timeout", 64'(n < max), 64'd1);
  endtask

  task automatic chk_owners(input string tag, input int a, input int b, input int c, input int cnt);
    int e[3];
    e[0] = a; e[1] = b; e[2] = c;
    chk({tag, "_count"}, 64'(owners.size()), 64'(cnt));
    for (int i = 0; i < cnt && i < owners.size(); i++) chk(tag, 64'(owners[i]), 64'(e[i]));
  endtask

  initial begin
    beat_t b;
    logic [63:0] exp_d[$];
    int base, n;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    i_ap_rst = 1'b1; to_bridge_tready = 1'b0;
    req_tvalid = '0; req_tlast = '0; req_tdata = '0; req_tkeep = '0;
    req_tid = '0; req_tdest = '0; req_tuser = '0;
    for (int k = 0; k < N; k++) acc_cnt[k] = 0;

    // 1: reset with idle inputs
    repeat (10) step(1);

    // 2: single 2-beat packet from requester 2
    b = '{data: 64'hABABABABCDCDCDCD, keep: 8'hFF, id: 16'hAEAE, dest: 16'hAFAF,
          user: 32'hA0A0A0A0, last: 1'b0};
    srcq[2].push_back(b);
    b.data = 64'hEFEFEFEFEFEFEFEF; b.last = 1'b1;
    srcq[2].push_back(b);
    owners.delete(); got.delete();
    drain(50);
    chk_owners("single_owner", 2, 0, 0, 1);
    chk("single_beats", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      chk("single_b0", got[0], 64'hABABABABCDCDCDCD);
      chk("single_b1", got[1], 64'hEFEFEFEFEFEFEFEF);
    end

    // 3: contention among 0,1,3 pending from reset release
    step(1);
    enq(0, 3); enq(1, 3); enq(3, 3);
    step(1);
    owners.delete();
    drain(100);
    chk_owners("contention_order", 0, 1, 3, 3);

    // 4: backpressure 1,0,0,1 during a 4-beat packet
    enq(2, 4);
    exp_d.delete();
    for (int j = 0; j < 4; j++) exp_d.push_back(srcq[2][j].data);
    tr_mode = 1; pidx = 0; got.delete(); owners.delete();
    drain(100);
    tr_mode = 0;
    chk("bp_beats", 64'(got.size()), 64'd4);
    for (int j = 0; j < 4 && j < got.size(); j++) chk("bp_data", got[j], exp_d[j]);

    // 5: fairness after requester 3 finishes, pointer wraps to 0
    owners.delete();
    enq(3, 2);
    drain(50);
    enq(0, 2); enq(3, 2);
    drain(50);
    chk_owners("wrap_order", 3, 0, 3, 3);

    // 6: reset after first beat of requester 1
    enq(1, 3);
    base = acc_cnt[1]; n = 0;
    while (acc_cnt[1] == base && n < 20) begin step(0); n++; end
    chk("midpkt_accept_timeout", 64'(n < 20), 64'd1);
    step(1);
    owners.delete();
    enq(3, 1);
    drain(50);
    chk_owners("post_reset_order", 1, 3, 0, 2);

    // random phase: random packets, random gaps, random backpressure
    gen_cnt = 0; got.delete();
    for (int p = 0; p < 40; p++) enq($urandom_range(0, N - 1), $urandom_range(1, 4));
    tr_mode = 2; rand_en = 1;
    drain(3000);
    chk("rand_delivered", 64'(got.size()), 64'(gen_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
